// File: rtl/mod_exp.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp
// Purpose  : Left-to-right square-and-multiply modular exponentiator,
//            result = base^exp mod mod. Each modular multiply is a serial
//            shift-and-add over WIDTH cycles. A multiply is done only for
//            exponent bits that are 1, so the total time depends on the data.
//            That timing is intentional and must not be equalised.
// Ports    : clk    - system clock, rising edge
//            rst    - asynchronous reset, active-high
//            start  - request, sampled only in IDLE
//            base   - message/ciphertext, latched on accepted start
//            exp    - exponent, latched on accepted start
//            mod    - modulus, latched on accepted start
//            result - base^exp mod mod, valid with finish, held afterwards
//            busy   - high from the accepting edge until DONE is entered
//            finish - single-cycle pulse while in DONE
//            err    - high with finish when the latched modulus is zero
// Revision : 1.0 - initial release
// ============================================================================
module mod_exp #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     mod,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 finish,
  output logic                 err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [BW-1:0]    C_BIT_TOP = BW'(WIDTH - 1);
  localparam logic [KW-1:0]    C_K_TOP   = KW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_SQR    = 3'd2,
    S_MUL    = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_mod;
  logic [WIDTH-1:0]     r_bred;   // base reduced mod m
  logic [WIDTH-1:0]     r_r;      // running exponentiation value
  logic [WIDTH-1:0]     r_acc;    // mulmod accumulator
  logic [BW-1:0]        r_bit;    // mulmod bit index, MSB first
  logic [KW-1:0]        r_k;      // exponent bit index
  logic [WIDTH-1:0]     r_result;
  logic                 r_busy;
  logic                 r_err;

  // One mulmod step: acc = 2*acc mod m, then optionally + a mod m.
  // Both intermediates need one extra bit since 2*acc and acc+a reach 2m-2.
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH:0]   w_mod_x;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH-1:0] w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_red;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_step_last;
  logic             w_mod_zero;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_REDUCE: begin w_op_a = C_ONE;  w_op_b = r_base; end
      S_SQR:    begin w_op_a = r_r;    w_op_b = r_r;    end
      S_MUL:    begin w_op_a = r_bred; w_op_b = r_r;    end
      default:  begin w_op_a = '0;     w_op_b = '0;     end
    endcase
  end

  assign w_mod_x     = {1'b0, r_mod};
  assign w_dbl       = {r_acc, 1'b0};
  assign w_dbl_red   = (w_dbl >= w_mod_x) ? WIDTH'(w_dbl - w_mod_x) : WIDTH'(w_dbl);
  assign w_sum       = {1'b0, w_dbl_red} + {1'b0, w_op_a};
  assign w_sum_red   = (w_sum >= w_mod_x) ? WIDTH'(w_sum - w_mod_x) : WIDTH'(w_sum);
  assign w_acc_next  = w_op_b[r_bit] ? w_sum_red : w_dbl_red;
  assign w_step_last = (r_bit == '0);
  assign w_mod_zero  = (r_mod == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_REDUCE;
      S_REDUCE: begin
        if (w_mod_zero)       w_state_next = S_DONE;
        else if (w_step_last) w_state_next = S_SQR;
      end
      S_SQR:    if (w_step_last) w_state_next = r_exp[r_k] ? S_MUL : S_NEXT;
      S_MUL:    if (w_step_last) w_state_next = S_NEXT;
      S_NEXT:   w_state_next = (r_k == '0) ? S_DONE : S_SQR;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_bred   <= '0;
      r_r      <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= base;
            r_exp    <= exp;
            r_mod    <= mod;
            r_acc    <= '0;
            r_bit    <= C_BIT_TOP;
            r_result <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_REDUCE: begin
          if (w_mod_zero) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
          end else if (w_step_last) begin
            r_bred <= w_acc_next;
            // 1 mod 1 is 0, so exp=0 with m=1 must yield 0
            r_r    <= (r_mod == C_ONE) ? '0 : C_ONE;
            r_k    <= C_K_TOP;
            r_acc  <= '0;
            r_bit  <= C_BIT_TOP;
          end else begin
            r_acc <= w_acc_next;
            r_bit <= r_bit - 1'b1;
          end
        end
        S_SQR, S_MUL: begin
          if (w_step_last) begin
            r_r   <= w_acc_next;
            r_acc <= '0;
            r_bit <= C_BIT_TOP;
          end else begin
            r_acc <= w_acc_next;
            r_bit <= r_bit - 1'b1;
          end
        end
        S_NEXT: begin
          if (r_k == '0) begin
            r_result <= r_r;
            r_busy   <= 1'b0;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign err    = r_err;
  assign finish = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mod_exp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_exp
// Purpose  : Self-checking bench for mod_exp. Expected result, err flag and
//            latency are pushed to a scoreboard queue when an operation is
//            started and popped when finish is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_exp;

  localparam int W  = 16;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exp = '0;
  logic [W-1:0]  mod = '0;
  logic [W-1:0]  result;
  logic          busy;
  logic          finish;
  logic          err;

  mod_exp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .mod    (mod),
    .result (result),
    .busy   (busy),
    .finish (finish),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Observations captured by do_op
  logic [W-1:0] obs_result, obs_res_held, obs_res_acc;
  logic         obs_err, obs_err_acc, obs_busy_acc, obs_busy_fin, obs_timeout;
  int           obs_lat;

  function automatic sb_t model(input logic [W-1:0] b, input logic [EW-1:0] e,
                                input logic [W-1:0] m);
    sb_t    x;
    longint r, bb, mm;
    if (m == '0) begin
      x.res = '0; x.err = 1'b1; x.lat = 1;
      return x;
    end
    mm = longint'(m);
    r  = 1 % mm;
    bb = longint'(b) % mm;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    x.res = W'(r);
    x.err = 1'b0;
    x.lat = W + EW * (W + 1) + W * $countones(e);
    return x;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge following finish (DUT back in IDLE).
  task automatic do_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] m);
    int n;
    base = b; exp = e; mod = m; start = 1'b1;
    sb.push_back(model(b, e, m));
    @(posedge clk); #1;
    start = 1'b0;
    obs_busy_acc = busy;
    obs_err_acc  = err;
    obs_res_acc  = result;
    n = 0;
    while (!finish && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    obs_timeout  = !finish;
    obs_lat      = n;
    obs_result   = result;
    obs_err      = err;
    obs_busy_fin = busy;
    @(posedge clk); #1;
    obs_res_held = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0h expected 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_op(input string name, input logic [W-1:0] b,
                         input logic [EW-1:0] e, input logic [W-1:0] m);
    sb_t ex;
    do_op(b, e, m);
    ex = sb.pop_front();
    checks++;
    if (obs_timeout) begin
      errors++; $display("FAIL %s timeout: no finish within 400 edges, expected edge %0d", name, ex.lat);
    end
    checks++; if (obs_result !== ex.res) begin errors++; $display("FAIL %s result: got %0d expected %0d", name, obs_result, ex.res); end
    checks++; if (obs_err !== ex.err) begin errors++; $display("FAIL %s err: got %b expected %b", name, obs_err, ex.err); end
    checks++; if (obs_lat !== ex.lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, ex.lat); end
    checks++; if (obs_busy_acc !== 1'b1) begin errors++; $display("FAIL %s busy_at_accept: got %b expected 1", name, obs_busy_acc); end
    checks++; if (obs_busy_fin !== 1'b0) begin errors++; $display("FAIL %s busy_at_finish: got %b expected 0", name, obs_busy_fin); end
    checks++; if (obs_res_held !== ex.res) begin errors++; $display("FAIL %s result_hold: got %0d expected %0d", name, obs_res_held, ex.res); end
  endtask

  task automatic test_err();
    test_op("err_mod0", 16'd123, 8'd7, 16'd0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b expected 1", err); end
    test_op("err_clear", 16'd3, 8'd4, 16'd7);
    checks++; if (obs_err_acc !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b expected 0", obs_err_acc); end
    checks++; if (obs_res_acc !== '0) begin errors++; $display("FAIL result_clear_on_start: got %0d expected 0", obs_res_acc); end
  endtask

  // start held high throughout; inputs scrambled mid-operation. The start
  // seen during DONE must be ignored, the one on the following cycle taken.
  task automatic test_hold_start();
    sb_t  ex;
    int   n;
    logic busy_ok;
    base = 16'd2; exp = 8'd3; mod = 16'd15; start = 1'b1;
    sb.push_back(model(16'd2, 8'd3, 16'd15));
    @(posedge clk); #1;
    n = 0; busy_ok = 1'b1;
    while (!finish && n < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      base = W'($urandom); exp = EW'($urandom); mod = W'($urandom);
      @(posedge clk); #1;
      n++;
    end
    ex = sb.pop_front();
    checks++; if (!finish) begin errors++; $display("FAIL hold_a timeout: no finish within 400 edges"); end
    checks++; if (result !== ex.res) begin errors++; $display("FAIL hold_a result: got %0d expected %0d", result, ex.res); end
    checks++; if (n !== ex.lat) begin errors++; $display("FAIL hold_a latency: got %0d expected %0d", n, ex.lat); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL hold_a busy_throughout: got %b expected 1", busy_ok); end
    base = 16'd20; exp = 8'd1; mod = 16'd15;
    sb.push_back(model(16'd20, 8'd1, 16'd15));
    @(posedge clk); #1;
    checks++; if ({busy, finish} !== 2'b00) begin errors++; $display("FAIL hold_done_ignore: got busy,finish=%b expected 00", {busy, finish}); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_b accept: got busy=%b expected 1", busy); end
    n = 0;
    while (!finish && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    ex = sb.pop_front();
    checks++; if (result !== ex.res || !finish) begin errors++; $display("FAIL hold_b result: got %0d expected %0d", result, ex.res); end
    checks++; if (n !== ex.lat) begin errors++; $display("FAIL hold_b latency: got %0d expected %0d", n, ex.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic seen;
    base = 16'd2; exp = 8'd3; mod = 16'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, finish, err} !== 3'b000 || result !== '0) begin
      errors++; $display("FAIL areset_outputs: got busy,finish,err=%b result=%0d expected 000 and 0", {busy, finish, err}, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (220) begin
      @(posedge clk); #1;
      if (finish) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_no_finish: got %b expected 0", seen); end
    test_op("after_reset", 16'd8, 8'd3, 16'd15);
  endtask

  initial begin
    test_reset();
    test_op("b2e3m15", 16'd2, 8'd3, 16'd15);
    test_op("b8e3m15", 16'd8, 8'd3, 16'd15);
    test_op("b20e1m15", 16'd20, 8'd1, 16'd15);
    test_op("b7e0m15", 16'd7, 8'd0, 16'd15);
    test_op("b0e5m15", 16'd0, 8'd5, 16'd15);
    test_op("b2e16mFFFF", 16'd2, 8'd16, 16'hFFFF);
    test_op("b9e5m1", 16'd9, 8'd5, 16'd1);
    test_op("b7e0m1", 16'd7, 8'd0, 16'd1);
    test_op("big", 16'hFFFE, 8'hFF, 16'hFFF1);
    test_err();
    test_hold_start();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
